mem_async_ctrl: RTL and testbench



---
 rtl/mem_async_pkg.sv | 27 ++
 rtl/mem_async_phase_cnt.sv | 28 ++
 rtl/mem_async_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_async_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_async_pkg.sv
// Shared types and constants for the asynchronous memory initiator.
package mem_async_pkg;

  localparam int unsigned ADDR_W_DEF     = 4;
  localparam int unsigned DATA_W_DEF     = 4;
  localparam int unsigned DEPTH_DEF      = 9;
  localparam int unsigned SETUP_CYC_DEF  = 1;
  localparam int unsigned STROBE_CYC_DEF = 2;
  localparam int unsigned HOLD_CYC_DEF   = 1;
  localparam int unsigned STAT_W         = 8;
  localparam int unsigned PH_W           = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP,
    ERR
  } state_t;

  // Counter preload for a phase lasting cyc cycles (counts down to zero).
  function automatic logic [PH_W-1:0] phase_load(input int unsigned cyc);
    return PH_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/mem_async_phase_cnt.sv
// Loadable down-counter with a zero flag, timing each memory phase.
module mem_async_phase_cnt
  import mem_async_pkg::*;
#(
  parameter int unsigned W = PH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_async_ctrl.sv
// Synchronous initiator for the level-sensitive async memory (setup/strobe/hold).
// Optional statistics counters enabled by MEM_ASYNC_CTRL_STATS_EN.
module mem_async_ctrl
  import mem_async_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
  parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ASYNC_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rd_cnt,
  output logic [STAT_W-1:0] stat_wr_cnt,
  output logic [STAT_W-1:0] stat_err_cnt
`endif
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_n;
  logic              ph_load, ph_zero;
  logic [PH_W-1:0]   ph_val;
  logic              accept;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              wr_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              ready_n, rsp_valid_n, rsp_err_n;
  logic              cs_n, wr_n, rd_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;

  assign accept = (state == IDLE) && req_valid;

  mem_async_phase_cnt #(.W(PH_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = ({1'b0, req_addr} >= DEPTH_V) ? ERR : SETUP;
      SETUP:   if (ph_zero) state_n = STROBE;
      STROBE:  if (ph_zero) state_n = HOLD;
      HOLD:    if (ph_zero) state_n = RESP;
      RESP:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ph_load = (state_n != state);
    ph_val  = '0;
    case (state_n)
      SETUP:   ph_val = phase_load(SETUP_CYC);
      STROBE:  ph_val = phase_load(STROBE_CYC);
      HOLD:    ph_val = phase_load(HOLD_CYC);
      default: ph_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    wr_sel      = accept ? req_write : wr_q;
    addr_sel    = accept ? req_addr  : addr_q;
    wdata_sel   = accept ? req_wdata : wdata_q;
    ready_n     = (state_n == IDLE);
    cs_n        = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
    wr_n        = (state_n == STROBE) && wr_sel;
    rd_n        = (state_n == STROBE) && !wr_sel;
    mem_addr_n  = cs_n ? addr_sel : '0;
    mem_wdata_n = cs_n ? wdata_sel : '0;
    rsp_valid_n = (state_n == RESP) || (state_n == ERR);
    rsp_err_n   = (state_n == ERR);
    rsp_rdata_n = ((state_n == RESP) && !wr_q) ? rdata_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_cs    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      req_ready <= ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
      mem_cs    <= cs_n;
      mem_wr    <= wr_n;
      mem_rd    <= rd_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Sample read data on the edge that closes the final strobe cycle.
      if ((state == STROBE) && ph_zero) begin
        rdata_q <= mem_rdata;
      end
    end
  end

`ifdef MEM_ASYNC_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (rsp_valid) begin
      if (rsp_err) begin
        if (stat_err_cnt != '1) stat_err_cnt <= stat_err_cnt + 1'b1;
      end else if (wr_q) begin
        if (stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1'b1;
      end else begin
        if (stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_async_ctrl.sv
// Randomized self-checking bench for mem_async_ctrl against a transaction-level model.
// Statistics checks are compiled in when MEM_ASYNC_CTRL_STATS_EN is defined.
module tb_mem_async_ctrl;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 9;
  localparam int S_CYC = 1;
  localparam int T_CYC = 2;
  localparam int H_CYC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_cs, mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ASYNC_CTRL_STATS_EN
  logic [7:0]    stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem_arr [16];
  logic [DW-1:0] ref_mem [16];

  always #5 clk = ~clk;

  mem_async_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
    .SETUP_CYC(S_CYC), .STROBE_CYC(T_CYC), .HOLD_CYC(H_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ASYNC_CTRL_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  // Level-sensitive memory macro: writes while cs&wr, reads while cs&rd.
  always @(mem_cs or mem_wr or mem_addr or mem_wdata)
    if (mem_cs && mem_wr) mem_arr[mem_addr] = mem_wdata;
  assign mem_rdata = (mem_cs && mem_rd) ? mem_arr[mem_addr] : 4'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full transaction; keep leaves req_valid high with junk fields afterwards.
  task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    int waitc, lat, cs_c, wr_c, rd_c, both_c, bad_c, rdy_c, first_strb;
    bit exp_err;
    int exp_lat;
    logic [DW-1:0] exp_rd;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept", 32'(req_ready), 32'(1));
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    exp_err = (int'(a) >= DEPTH);
    exp_lat = exp_err ? 1 : S_CYC + T_CYC + H_CYC + 1;
    exp_rd  = (!w && !exp_err) ? ref_mem[a] : '0;
    if (w && !exp_err) ref_mem[a] = d;
    @(posedge clk);
    #1;
    req_valid = keep;
    req_write = 1'($urandom); req_addr = 4'($urandom); req_wdata = 4'($urandom);
    lat = 0; cs_c = 0; wr_c = 0; rd_c = 0; both_c = 0; bad_c = 0; rdy_c = 0; first_strb = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_cs) cs_c++;
      if (mem_wr) wr_c++;
      if (mem_rd) rd_c++;
      if (mem_wr && mem_rd) both_c++;
      if ((mem_wr || mem_rd) && first_strb == 0) first_strb = k;
      if (mem_cs && (mem_addr != a || (w && mem_wdata != d))) bad_c++;
      if (!mem_cs && (mem_wr || mem_rd || mem_addr != '0 || mem_wdata != '0)) bad_c++;
      if (req_ready) rdy_c++;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("cs_cycles", 32'(cs_c), exp_err ? 0 : 32'(S_CYC + T_CYC + H_CYC));
    chk("wr_cycles", 32'(wr_c), (w && !exp_err) ? 32'(T_CYC) : 0);
    chk("rd_cycles", 32'(rd_c), (!w && !exp_err) ? 32'(T_CYC) : 0);
    chk("strobe_start", 32'(first_strb), exp_err ? 0 : 32'(S_CYC + 1));
    chk("both_strobes", 32'(both_c), 0);
    chk("pin_values", 32'(bad_c), 0);
    chk("ready_busy", 32'(rdy_c), 0);
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 0);
    chk("ready_after", 32'(req_ready), 32'(1));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_outs", 32'({rsp_valid, rsp_err, rsp_rdata, mem_cs, mem_wr, mem_rd, mem_addr, mem_wdata}), 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    @(negedge clk);
    apply_reset();

    // directed: write/read, errors, boundary address, back-to-back
    do_req(1'b1, 4'd3, 4'hA, 1'b0);
    do_req(1'b0, 4'd3, 4'h0, 1'b0);
    do_req(1'b0, 4'd9, 4'h0, 1'b0);
    do_req(1'b0, 4'd15, 4'h0, 1'b0);
    do_req(1'b1, 4'd8, 4'h6, 1'b0);
    do_req(1'b0, 4'd8, 4'h0, 1'b0);
    do_req(1'b1, 4'd0, 4'h5, 1'b1);
    do_req(1'b0, 4'd0, 4'h0, 1'b0);

    // reset in the middle of a write strobe
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 4'h7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (S_CYC + 1) @(negedge clk);
    chk("pre_rst_wr", 32'(mem_wr), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pins", 32'({mem_cs, mem_wr, mem_rd}), 0);
    chk("async_rst_rsp", 32'(rsp_valid), 0);
    chk("async_rst_ready", 32'(req_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    begin
      int rsp_seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_valid) rsp_seen++;
      end
      chk("no_rsp_after_rst", 32'(rsp_seen), 0);
    end
    // the strobe already reached the level-sensitive memory before reset
    ref_mem[5] = 4'h7;
    do_req(1'b0, 4'd5, 4'h0, 1'b0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      bit keep;
      keep = (i != 59) && ($urandom_range(0, 3) == 0);
      do_req(1'($urandom), 4'($urandom), 4'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MEM_ASYNC_CTRL_STATS_EN
    apply_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_arr[i];
    chk("stat_rst", 32'({stat_rd_cnt, stat_wr_cnt, stat_err_cnt}), 0);
    do_req(1'b1, 4'd1, 4'h1, 1'b0);
    do_req(1'b1, 4'd2, 4'h2, 1'b0);
    do_req(1'b1, 4'd8, 4'h3, 1'b0);
    do_req(1'b0, 4'd1, 4'h0, 1'b0);
    do_req(1'b0, 4'd2, 4'h0, 1'b0);
    do_req(1'b0, 4'd12, 4'h0, 1'b0);
    chk("stat_wr", 32'(stat_wr_cnt), 32'(3));
    chk("stat_rd", 32'(stat_rd_cnt), 32'(2));
    chk("stat_err", 32'(stat_err_cnt), 32'(1));
    for (int i = 0; i < 300; i++) do_req(1'b0, 4'(i % 9), 4'h0, 1'b0);
    chk("stat_rd_sat", 32'(stat_rd_cnt), 32'(255));
    chk("stat_wr_hold", 32'(stat_wr_cnt), 32'(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
